hash_sched: RTL and testbench
=============================

# hash_sched

Round-robin scheduler that shares the single SHA3-based hash unit between up to NREQ requesters (commitment, seed-expansion, challenge and per-party message hashing in the Picnic signing flow). It arbitrates, drives the hash unit's mode/start handshake, holds a one-hot grant for the external operand mux, captures the digest, and returns a per-requester ack or timeout error. It sits between the signing-step controllers and the hash unit.

## Interface
- NREQ, 4, number of requesters (2..8)
- DW, 512, digest width
- TIMEOUT, 4096, max cycles from hash start to done-low before abort (≥16)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high
- req_i  in  NREQ  per-requester request level, held until ack_o/err_o seen
- req_mode_i  in  4*NREQ  mode for requester k at [4k+3:4k] (0..3 valid)
- gnt_o  out  NREQ  one-hot grant, held for whole transaction; selects operands externally
- ack_o  out  NREQ  one-cycle pulse, digest_o valid for requester k
- err_o  out  NREQ  one-cycle pulse, timeout abort for requester k
- digest_o  out  DW  registered digest of last successful transaction
- busy_o  out  1  high in every state except IDLE
- hash_mode_o  out  4  mode to hash unit, registered at grant
- hash_start_o  out  1  level start to hash unit
- hash_done_i  in  1  hash unit done level (rises when finished, falls after start drops)
- hash_value_i  in  DW  hash unit digest, valid while hash_done_i high

## Operation
- States: IDLE, GRANT, WAIT, DRAIN, RESP, ABORT.
- IDLE: if any req_i, pick first requesting index at or after pointer ptr (wrapping mod NREQ); register gnt_o, hash_mode_o; → GRANT. ptr ← winner+1 mod NREQ.
- GRANT: one settle cycle for operand mux; hash_start_o ← 1; → WAIT.
- WAIT: on hash_done_i=1: digest_o ← hash_value_i, hash_start_o ← 0, → DRAIN.
- DRAIN: on hash_done_i=0 → RESP.
- RESP: ack_o[winner] pulses; gnt_o ← 0; → IDLE.
- ABORT: hash_start_o=0, err_o[winner] pulses, gnt_o ← 0, digest_o unchanged; → IDLE.
- Timeout counter cleared in GRANT, increments in WAIT and DRAIN; reaching TIMEOUT-1 → ABORT (takes priority over simultaneous done).
- Requester dropping req_i mid-transaction: ignored; transaction completes and ack still pulses.
- req_mode_i > 3: forwarded unchanged; hash unit behaviour is the requester's problem.
- Requester must have req_i low in the cycle after its ack/err; otherwise it is re-arbitrated normally.
- Single requester continuously requesting is re-granted each time; no starvation: any requester waits at most NREQ-1 transactions.

## Timing
- Reset values: gnt_o, ack_o, err_o, hash_start_o, busy_o, hash_mode_o = 0; digest_o = 0; ptr = 0; state IDLE. Reset mid-transaction drops hash_start_o immediately (async).
- req seen in IDLE at cycle 0 → gnt_o/hash_mode_o valid cycle 1 → hash_start_o high cycle 2.
- With hash unit raising done L cycles after start and clearing it one cycle after start falls: ack_o at cycle L+5, back in IDLE cycle L+6.
- ack_o and err_o never both high; at most one bit of each set.
- digest_o stable from DRAIN until next successful WAIT capture.

## Structure
- Package hash_sched_pkg: state enum, mode constants (MODE_SEED=0, MODE_AUX=1, MODE_COMMIT=2, MODE_CHAL=3), DW default.
- Sub-module rr_arbiter: combinational rotating-priority pick (req, ptr → one-hot winner, index, any); instantiated once.

## Test plan
- Single request k=1, mode 2, engine L=10, digest 512'hA5…: gnt_o=4'b0010 at cycle 1, start at 2, ack_o=4'b0010 at cycle 15, digest_o matches.
- All four request together from reset: grants in order 0,1,2,3; then req 0 and 3 again with ptr=0 → 0 then 3.
- Engine never raises done, TIMEOUT=16: err_o pulses for winner, hash_start_o low, digest_o unchanged, next requester served.
- Requester drops req_i during WAIT: transaction completes, ack_o still pulses, no re-grant.
- Assert reset during WAIT: all outputs 0 same cycle, next request granted from ptr=0.
- Done held high for 3 extra cycles after start falls: stays in DRAIN, ack only after done low.

Source files
------------

// File: rtl/hash_sched_pkg.sv
// Shared types and constants for the hash-unit scheduler.
package hash_sched_pkg;

  localparam int DW_DEFAULT = 512;

  localparam logic [3:0] MODE_SEED   = 4'd0;
  localparam logic [3:0] MODE_AUX    = 4'd1;
  localparam logic [3:0] MODE_COMMIT = 4'd2;
  localparam logic [3:0] MODE_CHAL   = 4'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_WAIT,
    ST_DRAIN,
    ST_RESP,
    ST_ABORT
  } state_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/hash_sched_rr_arbiter.sv
// Rotating-priority pick: first requester at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  // NOTE: every output gets a default before the loop, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    // Walk offsets from farthest to nearest so the nearest requester wins last.
    for (int i = NREQ - 1; i >= 0; i--) begin
      for (int k = 0; k < NREQ; k++) begin
        if (i_req[k] && (k == int'(i_ptr) + i || k == int'(i_ptr) + i - NREQ)) begin
          o_gnt    = '0;
          o_gnt[k] = 1'b1;
          o_idx    = IW'(k);
          o_any    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hash_sched.sv
// Round-robin scheduler sharing one hash unit between NREQ requesters,
// with start/done handshake, digest capture and timeout abort.
module hash_sched
  import hash_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int DW      = DW_DEFAULT,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_i,
  input  logic [4*NREQ-1:0] req_mode_i,
  output logic [NREQ-1:0]   gnt_o,
  output logic [NREQ-1:0]   ack_o,
  output logic [NREQ-1:0]   err_o,
  output logic [DW-1:0]     digest_o,
  output logic              busy_o,
  output logic [3:0]        hash_mode_o,
  output logic              hash_start_o,
  input  logic              hash_done_i,
  input  logic [DW-1:0]     hash_value_i
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);

  state_t            r_state, w_state_nxt;
  logic [NREQ-1:0]   r_gnt;
  logic [3:0]        r_mode;
  logic              r_start;
  logic [DW-1:0]     r_digest;
  logic [IW-1:0]     r_ptr;
  logic [CW-1:0]     r_cnt;

  logic [NREQ-1:0]   w_gnt;
  logic [IW-1:0]     w_idx;
  logic              w_any;
  logic [3:0]        w_mode;
  logic              w_timeout;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .i_req (req_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  always_comb begin
    w_mode = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt[k]) w_mode = req_mode_i[4*k +: 4];
    end
  end

  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  // NOTE: state and datapath registers use non-blocking assignments only,
  // so every flop samples values from before the clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Timeout outranks a simultaneous done in both WAIT and DRAIN.
  always_comb begin
    w_state_nxt = r_state;
    ack_o       = '0;
    err_o       = '0;
    case (r_state)
      ST_IDLE:  if (w_any) w_state_nxt = ST_GRANT;
      ST_GRANT: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_timeout)       w_state_nxt = ST_ABORT;
        else if (hash_done_i) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_timeout)         w_state_nxt = ST_ABORT;
        else if (!hash_done_i) w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        ack_o       = r_gnt;
        w_state_nxt = ST_IDLE;
      end
      ST_ABORT: begin
        err_o       = r_gnt;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt    <= '0;
      r_mode   <= '0;
      r_start  <= 1'b0;
      r_digest <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt  <= w_gnt;
            r_mode <= w_mode;
            r_ptr  <= IW'(wrap_inc(int'(w_idx), NREQ));
          end
        end
        ST_GRANT: begin
          r_start <= 1'b1;
          r_cnt   <= '0;
        end
        ST_WAIT: begin
          if (w_timeout) begin
            r_start <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
            if (hash_done_i) begin
              r_digest <= hash_value_i;
              r_start  <= 1'b0;
            end
          end
        end
        ST_DRAIN: if (!w_timeout) r_cnt <= r_cnt + CW'(1);
        ST_RESP, ST_ABORT: r_gnt <= '0;
        default: ;
      endcase
    end
  end

  assign gnt_o        = r_gnt;
  assign hash_mode_o  = r_mode;
  assign hash_start_o = r_start;
  assign digest_o     = r_digest;
  assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: tb/tb_hash_sched.sv
// Randomized bench for hash_sched with a behavioural hash-unit model and a
// spec-level round-robin/timing reference model.
module tb_hash_sched;
  import hash_sched_pkg::*;

  localparam int NREQ    = 4;
  localparam int DW      = 512;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_i;
  logic [4*NREQ-1:0] req_mode_i;
  logic [NREQ-1:0]   gnt_o, ack_o, err_o;
  logic [DW-1:0]     digest_o;
  logic              busy_o;
  logic [3:0]        hash_mode_o;
  logic              hash_start_o;
  logic              hash_done_i;
  logic [DW-1:0]     hash_value_i;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // hash unit model state
  int          eng_lat   = 4;
  int          eng_hold  = 0;
  bit          eng_never = 1'b0;
  logic [DW-1:0] eng_digest;
  bit          eng_busy  = 1'b0;
  bit          eng_fall_seen = 1'b0;
  int          eng_t0    = 0;
  int          eng_fall_t = 0;

  // reference model state
  int          m_ptr = 0;
  logic [DW-1:0] m_digest = '0;

  always #5 clk = ~clk;

  hash_sched #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_i        (req_i),
    .req_mode_i   (req_mode_i),
    .gnt_o        (gnt_o),
    .ack_o        (ack_o),
    .err_o        (err_o),
    .digest_o     (digest_o),
    .busy_o       (busy_o),
    .hash_mode_o  (hash_mode_o),
    .hash_start_o (hash_start_o),
    .hash_done_i  (hash_done_i),
    .hash_value_i (hash_value_i)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] v;
    for (int i = 0; i < DW/32; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // First requester at or after the model pointer, wrapping.
  function automatic int model_pick(input logic [NREQ-1:0] r);
    for (int i = 0; i < NREQ; i++)
      if (r[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    return -1;
  endfunction

  // One clock; sample #1 after the edge, then update the hash unit model.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (hash_start_o) begin
      if (!eng_busy) begin
        eng_busy = 1'b1;
        eng_t0   = cyc;
      end
      if (!eng_never && !hash_done_i && (cyc - eng_t0 >= eng_lat)) begin
        hash_done_i  = 1'b1;
        hash_value_i = eng_digest;
      end
    end else begin
      eng_busy = 1'b0;
      if (hash_done_i) begin
        if (!eng_fall_seen) begin
          eng_fall_seen = 1'b1;
          eng_fall_t    = cyc;
        end
        if (cyc - eng_fall_t >= 1 + eng_hold) begin
          hash_done_i   = 1'b0;
          eng_fall_seen = 1'b0;
          hash_value_i  = rand_dw();
        end
      end
    end
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    req_i         = '0;
    req_mode_i    = '0;
    hash_done_i   = 1'b0;
    hash_value_i  = rand_dw();
    eng_busy      = 1'b0;
    eng_fall_seen = 1'b0;
    eng_never     = 1'b0;
    eng_hold      = 0;
    repeat (2) @(posedge clk);
    #1;
    reset    = 1'b0;
    m_ptr    = 0;
    m_digest = '0;
  endtask

  // Called in the IDLE cycle where arbitration happens (cycle 0); returns
  // in the IDLE cycle after the response.
  task automatic run_txn(input int lat, input int hold, input bit never,
                         input int drop_at, input logic [DW-1:0] dig,
                         output int who);
    int              exp_i;
    int              c;
    bit              fin;
    logic [NREQ-1:0] exp_gnt;
    logic [3:0]      exp_mode;
    exp_i = model_pick(req_i);
    who   = exp_i;
    if (exp_i < 0) begin
      errors++;
      $display("FAIL txn_setup: no requester active, got %b required nonzero", req_i);
      return;
    end
    exp_gnt        = '0;
    exp_gnt[exp_i] = 1'b1;
    exp_mode       = req_mode_i[4*exp_i +: 4];
    eng_lat    = lat;
    eng_hold   = hold;
    eng_never  = never;
    eng_digest = dig;
    m_ptr      = (exp_i + 1) % NREQ;
    c   = 0;
    fin = 1'b0;
    while (!fin && c < 200) begin
      tick();
      c++;
      if (c == drop_at) req_i[exp_i] = 1'b0;
      if (c == 1) begin
        checks++;
        if (gnt_o !== exp_gnt || hash_mode_o !== exp_mode || busy_o !== 1'b1 || hash_start_o !== 1'b0) begin
          errors++;
          $display("FAIL grant: got gnt=%b mode=%0d busy=%b start=%b required gnt=%b mode=%0d busy=1 start=0",
                   gnt_o, hash_mode_o, busy_o, hash_start_o, exp_gnt, exp_mode);
        end
      end
      if (c == 2) begin
        checks++;
        if (hash_start_o !== 1'b1 || digest_o !== m_digest) begin
          errors++;
          $display("FAIL start: got start=%b digest=%h required start=1 digest=%h", hash_start_o, digest_o, m_digest);
        end
      end
      checks++;
      if ((ack_o & err_o) != '0 || $countones(ack_o) > 1 || $countones(err_o) > 1) begin
        errors++;
        $display("FAIL resp_onehot: got ack=%b err=%b required exclusive one-hot", ack_o, err_o);
      end
      if (ack_o != '0 || err_o != '0) begin
        fin = 1'b1;
        checks++;
        if (never) begin
          if (err_o !== exp_gnt || ack_o !== '0 || c != TIMEOUT + 2 || hash_start_o !== 1'b0 || digest_o !== m_digest) begin
            errors++;
            $display("FAIL abort: got err=%b ack=%b cycle=%0d start=%b required err=%b ack=0 cycle=%0d start=0 digest unchanged",
                     err_o, ack_o, c, hash_start_o, exp_gnt, TIMEOUT + 2);
          end
        end else begin
          m_digest = dig;
          if (ack_o !== exp_gnt || err_o !== '0 || c != lat + 5 + hold || digest_o !== m_digest) begin
            errors++;
            $display("FAIL ack: got ack=%b err=%b cycle=%0d digest=%h required ack=%b err=0 cycle=%0d digest=%h",
                     ack_o, err_o, c, digest_o, exp_gnt, lat + 5 + hold, m_digest);
          end
        end
        req_i[exp_i] = 1'b0;
      end
    end
    if (!fin) begin
      errors++;
      $display("FAIL resp_timeout: no ack/err within %0d cycles, required one", c);
    end
    eng_never = 1'b0;
    tick();
    checks++;
    if (busy_o !== 1'b0 || gnt_o !== '0) begin
      errors++;
      $display("FAIL back_idle: got busy=%b gnt=%b required busy=0 gnt=0", busy_o, gnt_o);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (gnt_o !== '0 || ack_o !== '0 || err_o !== '0 || hash_start_o !== 1'b0 ||
        busy_o !== 1'b0 || hash_mode_o !== 4'd0 || digest_o !== '0) begin
      errors++;
      $display("FAIL reset_vals: got gnt=%b ack=%b err=%b start=%b busy=%b mode=%0d required all zero",
               gnt_o, ack_o, err_o, hash_start_o, busy_o, hash_mode_o);
    end
    repeat (3) tick();
    checks++;
    if (busy_o !== 1'b0 || gnt_o !== '0) begin
      errors++;
      $display("FAIL idle_no_req: got busy=%b gnt=%b required 0/0", busy_o, gnt_o);
    end
  endtask

  task automatic test_single();
    int who;
    do_reset();
    req_mode_i[7:4] = MODE_COMMIT;
    req_i           = 4'b0010;
    run_txn(10, 0, 1'b0, 0, {16{32'hA5A5A5A5}}, who);
  endtask

  task automatic test_round_robin();
    int who;
    do_reset();
    req_mode_i = {MODE_CHAL, MODE_COMMIT, MODE_AUX, MODE_SEED};
    req_i      = 4'b1111;
    for (int n = 0; n < 4; n++) run_txn($urandom_range(1, 8), 0, 1'b0, 0, rand_dw(), who);
    req_i = 4'b1001;
    for (int n = 0; n < 2; n++) run_txn($urandom_range(1, 8), 0, 1'b0, 0, rand_dw(), who);
  endtask

  task automatic test_random();
    int who;
    do_reset();
    for (int n = 0; n < 24; n++) begin
      for (int k = 0; k < NREQ; k++)
        if (!req_i[k]) req_mode_i[4*k +: 4] = 4'($urandom_range(0, 15));
      req_i = req_i | NREQ'($urandom_range(0, (1 << NREQ) - 1));
      if (req_i == '0) req_i[$urandom_range(0, NREQ - 1)] = 1'b1;
      run_txn($urandom_range(1, 8), $urandom_range(0, 2), 1'b0, 0, rand_dw(), who);
    end
  endtask

  task automatic test_timeout();
    int who;
    do_reset();
    req_mode_i = $urandom;
    req_i      = 4'b0101;
    run_txn(4, 0, 1'b1, 0, rand_dw(), who);
    run_txn(4, 0, 1'b0, 0, rand_dw(), who);
  endtask

  task automatic test_drop_req();
    int who;
    do_reset();
    req_mode_i = $urandom;
    req_i      = 4'b1000;
    run_txn(6, 0, 1'b0, 4, rand_dw(), who);
    repeat (3) begin
      tick();
      checks++;
      if (gnt_o !== '0 || busy_o !== 1'b0) begin
        errors++;
        $display("FAIL no_regrant: got gnt=%b busy=%b required 0/0", gnt_o, busy_o);
      end
    end
  endtask

  task automatic test_done_hold();
    int who;
    do_reset();
    req_mode_i = $urandom;
    req_i      = 4'b0100;
    run_txn(5, 3, 1'b0, 0, rand_dw(), who);
  endtask

  task automatic test_reset_mid();
    int who;
    do_reset();
    req_mode_i = $urandom;
    req_i      = 4'b0100;
    run_txn(3, 0, 1'b0, 0, rand_dw(), who);
    req_i      = 4'b0100;
    eng_lat    = 10;
    eng_digest = rand_dw();
    repeat (4) tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (gnt_o !== '0 || ack_o !== '0 || err_o !== '0 || hash_start_o !== 1'b0 ||
        busy_o !== 1'b0 || hash_mode_o !== 4'd0 || digest_o !== '0) begin
      errors++;
      $display("FAIL reset_mid: got gnt=%b start=%b busy=%b mode=%0d ack=%b err=%b required all zero",
               gnt_o, hash_start_o, busy_o, hash_mode_o, ack_o, err_o);
    end
    @(posedge clk);
    #1;
    reset         = 1'b0;
    hash_done_i   = 1'b0;
    eng_busy      = 1'b0;
    eng_fall_seen = 1'b0;
    m_ptr         = 0;
    m_digest      = '0;
    req_i         = 4'b1001;
    run_txn(4, 0, 1'b0, 0, rand_dw(), who);
  endtask

  initial begin
    reset        = 1'b1;
    req_i        = '0;
    req_mode_i   = '0;
    hash_done_i  = 1'b0;
    hash_value_i = '0;
    eng_digest   = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_timeout();
    test_drop_req();
    test_done_hold();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
